// File: rtl/pwm_out_gen.sv
// RC/ESC PWM transmitter: 0..MAX_CMD command -> MIN..MIN+MAX*STEP cycle pulse every FRAME_CYCLES,
// with clamp, frame-boundary shadow load, arm gate and stale-command failsafe.
module pwm_out_gen #(
  parameter int FRAME_CYCLES   = 1000000,
  parameter int MIN_CYCLES     = 50000,
  parameter int STEP_CYCLES    = 50,
  parameter int MAX_CMD        = 1000,
  parameter int TIMEOUT_FRAMES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] ratio,
  input  logic        ratio_valid,
  input  logic        arm,
  output logic        pwmsignal,
  output logic        frame_start,
  output logic        failsafe,
  output logic [12:0] active_ratio
);
  localparam int KW = 20;
  localparam int WW = 17;
  localparam int CW = 13;
  localparam int SW = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [KW-1:0] K_LAST    = KW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] CMD_MAX   = CW'(MAX_CMD);
  localparam logic [WW-1:0] W_MIN     = WW'(MIN_CYCLES);
  localparam logic [WW-1:0] W_STEP    = WW'(STEP_CYCLES);
  localparam logic [SW-1:0] STALE_MAX = SW'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {HIGH, LOW, LOAD} phase_t;

  phase_t        state, state_nxt;
  logic [KW-1:0] k, width_last;
  logic [WW-1:0] width, cand_width;
  logic [CW-1:0] pending, cmd_clamped, eff;
  logic [SW-1:0] stale, stale_nxt;
  logic          pwm_d, load, gate;

  // Frame phase mirrors k: HIGH while k < width, LOAD on the final cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= HIGH;
    else     state <= state_nxt;
  end

  assign width_last = KW'(width) - KW'(1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      HIGH:    if (k == width_last)       state_nxt = LOW;
      LOW:     if (k == K_LAST - KW'(1))  state_nxt = LOAD;
      LOAD:                               state_nxt = HIGH;
      default:                            state_nxt = HIGH;
    endcase
  end

  always_comb begin
    pwm_d = (state == HIGH);
    load  = (state == LOAD);
  end

  assign cmd_clamped = (ratio > CMD_MAX) ? CMD_MAX : ratio;
  assign gate        = arm && !failsafe;
  assign eff         = gate ? pending : '0;

  always_comb begin
    stale_nxt = stale;
    if (ratio_valid)                     stale_nxt = '0;
    else if (load && stale < STALE_MAX)  stale_nxt = stale + SW'(1);
  end

  // cand_width tracks pending so the boundary load is a plain register copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      k            <= '0;
      pwmsignal    <= 1'b0;
      frame_start  <= 1'b0;
      failsafe     <= 1'b1;
      active_ratio <= '0;
      width        <= W_MIN;
      cand_width   <= W_MIN;
      pending      <= '0;
      stale        <= STALE_MAX;
    end else begin
      k           <= load ? '0 : k + KW'(1);
      pwmsignal   <= pwm_d;
      frame_start <= (k == '0);
      stale       <= stale_nxt;
      failsafe    <= (stale_nxt >= STALE_MAX);
      if (ratio_valid) begin
        pending    <= cmd_clamped;
        cand_width <= W_MIN + WW'(cmd_clamped) * W_STEP;
      end
      if (load) begin
        active_ratio <= eff;
        width        <= gate ? cand_width : W_MIN;
      end
    end
  end
endmodule

// File: tb/tb_pwm_out_gen.sv
// Scoreboarded bench for pwm_out_gen at reduced frame size (2000-cycle frame, 100..1100 pulse).
module tb_pwm_out_gen;
  localparam int FR = 2000, MN = 100, ST = 1, MX = 1000, TO = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] ratio = '0;
  logic        ratio_valid = 1'b0;
  logic        arm = 1'b0;
  logic        pwmsignal, frame_start, failsafe;
  logic [12:0] active_ratio;

  pwm_out_gen #(
    .FRAME_CYCLES(FR), .MIN_CYCLES(MN), .STEP_CYCLES(ST), .MAX_CMD(MX), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .rst(rst), .ratio(ratio), .ratio_valid(ratio_valid), .arm(arm),
    .pwmsignal(pwmsignal), .frame_start(frame_start), .failsafe(failsafe),
    .active_ratio(active_ratio)
  );

  always #5 clk = ~clk;

  typedef struct {int w; int ar;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3*FR);
    if (!frame_start) chk("frame_start_timeout", 0, 1);
  endtask

  // Wait for the next frame and record what its pulse must look like.
  task automatic frame(int w, int ar);
    exp_t e;
    wait_fs();
    e.w = w; e.ar = ar;
    q.push_back(e);
  endtask

  task automatic strobe(int r);
    ratio = 13'(r);
    ratio_valid = 1'b1;
    @(negedge clk);
    ratio_valid = 1'b0;
  endtask

  // Monitor: measure each frame's high run and period, compare against the queue.
  initial begin
    bit meas = 0, have_prev = 0;
    int cnt = 0, per = 0, ar = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        meas = 0; have_prev = 0; q.delete();
      end else begin
        if (frame_start) begin
          if (have_prev) chk("period", per, FR);
          per = 1; have_prev = 1; meas = 1; cnt = 0; ar = int'(active_ratio);
        end else per++;
        if (meas) begin
          if (pwmsignal) cnt++;
          else begin
            meas = 0;
            if (q.size() == 0) chk("scoreboard_empty", 0, 1);
            else begin
              e = q.pop_front();
              chk("width", cnt, e.w);
              chk("active_ratio", ar, e.ar);
            end
          end
        end else if (pwmsignal) begin
          failures++;
          $display("FAIL second_high_run actual=1 expected=0 t=%0t", $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_pwm", int'(pwmsignal), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_active_ratio", int'(active_ratio), 0);
    chk("rst_failsafe", int'(failsafe), 1);
    // basic disarmed cycle
    rst = 1'b0;
    frame(100, 0);
    chk("first_pwm", int'(pwmsignal), 1);
    frame(100, 0);
    chk("failsafe_idle", int'(failsafe), 1);
    // normal command, strobe inside the current pulse
    arm = 1'b1;
    idle(50);
    chk("failsafe_pre", int'(failsafe), 1);
    strobe(500);
    chk("failsafe_clear", int'(failsafe), 0);
    chk("active_mid_frame", int'(active_ratio), 0);
    frame(600, 500);
    // clamp and extremes
    idle(700);  strobe(1500); frame(1100, 1000);
    idle(1200); strobe(0);    frame(100, 0);
    idle(700);  strobe(1000); frame(1100, 1000);
    // boundary strobe lands on the load edge
    idle(1200); strobe(800);  frame(900, 800);
    idle(1998); strobe(200);
    frame(900, 800);
    frame(300, 200);
    // failsafe after five loads without strobes
    idle(700); strobe(700);
    frame(800, 700);
    frame(800, 700);
    frame(800, 700);
    frame(800, 700);
    chk("failsafe_before_timeout", int'(failsafe), 0);
    frame(800, 700);
    chk("failsafe_timeout", int'(failsafe), 1);
    frame(100, 0);
    idle(700); strobe(300);
    chk("failsafe_recover", int'(failsafe), 0);
    frame(400, 300);
    // disarm mid-pulse
    idle(1200); strobe(900);
    frame(1000, 900);
    idle(50); arm = 1'b0;
    frame(100, 0);
    arm = 1'b1;
    frame(1000, 900);
    // reset mid-pulse
    idle(200);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pwm", int'(pwmsignal), 0);
    chk("midrst_frame_start", int'(frame_start), 0);
    chk("midrst_active_ratio", int'(active_ratio), 0);
    chk("midrst_failsafe", int'(failsafe), 1);
    idle(2);
    rst = 1'b0;
    frame(100, 0);
    chk("restart_pwm", int'(pwmsignal), 1);
    frame(100, 0);
    idle(300);
    chk("scoreboard_leftover", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
